// File: rtl/chords_pkg.sv
// Shared widths, sample type and allocation-decision encoding for the chord synth voices.
package chords_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 16;
    localparam int DEFAULT_NOTE_WIDTH   = 6;

    typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        ALLOC_NONE  = 2'd0,
        ALLOC_FREE  = 2'd1,
        ALLOC_STEAL = 2'd2,
        ALLOC_DROP  = 2'd3
    } alloc_kind_e;

endpackage

// File: rtl/voice_mixer.sv
// Sums all voice samples at a widened width and clamps the result to the signed output range.
module voice_mixer
    import chords_pkg::*;
#(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
) (
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
    output logic [SAMPLE_WIDTH-1:0]            mix
);
    localparam int SUM_W = SAMPLE_WIDTH + $clog2(NUM_VOICES);
    localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_S = {{(SUM_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

    logic signed [SUM_W-1:0] sum_s;

    // Sign-extend each voice before accumulating so the wide sum cannot wrap.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum_s = sum_s + SUM_W'(signed'(voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        end
        if (sum_s > MAX_S) begin
            mix = MAX_S[SAMPLE_WIDTH-1:0];
        end else if (sum_s < MIN_S) begin
            mix = MIN_S[SAMPLE_WIDTH-1:0];
        end else begin
            mix = sum_s[SAMPLE_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: round-robin note dispatch, age-ranked voices, registered saturating mix.
// Build option: define VOICE_ALLOC_STEAL_EN to re-load the oldest voice when every voice is busy.
module voice_allocator
    import chords_pkg::*;
#(
    parameter int NUM_VOICES   = 3,
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int NOTE_WIDTH   = DEFAULT_NOTE_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_note,
    input  logic [NOTE_WIDTH-1:0]              note_in,
    input  logic [NUM_VOICES-1:0]              voice_done,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]              load,
    output logic [NOTE_WIDTH-1:0]              load_note,
    output logic [NUM_VOICES-1:0]              voice_busy,
    output logic                               player_available,
    output logic                               note_dropped,
    output logic [SAMPLE_WIDTH-1:0]            sample_out
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0]   load_q, load_d;
    logic [NOTE_WIDTH-1:0]   load_note_q, load_note_d;
    logic [NUM_VOICES-1:0]   busy_q, busy_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        rank_q [NUM_VOICES];
    logic [IDX_W-1:0]        rank_d [NUM_VOICES];
    logic                    note_dropped_q, note_dropped_d;
    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;

    logic [NUM_VOICES-1:0]   freed_s, eligible_s;
    logic                    found_s;
    logic [IDX_W-1:0]        cand_s, pick_s, victim_s, target_s;
    logic [IDX_W-1:0]        below_s [NUM_VOICES];
    alloc_kind_e             kind_s;
    logic [SAMPLE_WIDTH-1:0] mix_s;

    voice_mixer #(
        .NUM_VOICES   (NUM_VOICES),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_mixer (
        .voice_sample (voice_sample),
        .mix          (mix_s)
    );

    // Round-robin search for the first free voice; a voice finishing this cycle counts as free.
    always_comb begin
        freed_s    = voice_done & busy_q;
        eligible_s = ~busy_q | freed_s;
        found_s    = 1'b0;
        pick_s     = '0;
        cand_s     = '0;
        for (int off = 0; off < NUM_VOICES; off++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + off) % NUM_VOICES);
            if (!found_s && eligible_s[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Classify the request; the oldest busy voice always carries the top rank.
    always_comb begin
        victim_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] == IDX_W'(NUM_VOICES - 1)) begin
                victim_s = IDX_W'(i);
            end else begin
                victim_s = victim_s;
            end
        end
        if (!new_note) begin
            kind_s = ALLOC_NONE;
        end else if (found_s) begin
            kind_s = ALLOC_FREE;
        end else begin
`ifdef VOICE_ALLOC_STEAL_EN
            kind_s = ALLOC_STEAL;
`else
            kind_s = ALLOC_DROP;
`endif
        end
        target_s = (kind_s == ALLOC_STEAL) ? victim_s : pick_s;
    end

    // Per voice, count finishing voices that were younger, to keep busy ranks contiguous from 0.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            below_s[i] = '0;
            for (int j = 0; j < NUM_VOICES; j++) begin
                if (freed_s[j] && (rank_q[j] < rank_q[i])) begin
                    below_s[i] = below_s[i] + IDX_W'(1);
                end else begin
                    below_s[i] = below_s[i];
                end
            end
        end
    end

    // Next-state: load strobe, occupancy, pointer, drop pulse and age ranks.
    always_comb begin
        load_d         = '0;
        load_note_d    = '0;
        busy_d         = busy_q & ~freed_s;
        rr_ptr_d       = rr_ptr_q;
        note_dropped_d = (kind_s == ALLOC_DROP);
        sample_d       = mix_s;
        if ((kind_s == ALLOC_FREE) || (kind_s == ALLOC_STEAL)) begin
            load_d[target_s] = 1'b1;
            load_note_d      = note_in;
            busy_d[target_s] = 1'b1;
            rr_ptr_d         = (target_s == IDX_W'(NUM_VOICES - 1)) ? '0 : target_s + IDX_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (((kind_s == ALLOC_FREE) || (kind_s == ALLOC_STEAL)) && (IDX_W'(i) == target_s)) begin
                rank_d[i] = '0;
            end else if (busy_q[i] && !freed_s[i]) begin
                if ((kind_s == ALLOC_FREE) ||
                    ((kind_s == ALLOC_STEAL) && (rank_q[i] < rank_q[target_s]))) begin
                    rank_d[i] = rank_q[i] - below_s[i] + IDX_W'(1);
                end else begin
                    rank_d[i] = rank_q[i] - below_s[i];
                end
            end else begin
                rank_d[i] = '0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q         <= '0;
            load_note_q    <= '0;
            busy_q         <= '0;
            rr_ptr_q       <= '0;
            note_dropped_q <= 1'b0;
            sample_q       <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= '0;
            end
        end else begin
            load_q         <= load_d;
            load_note_q    <= load_note_d;
            busy_q         <= busy_d;
            rr_ptr_q       <= rr_ptr_d;
            note_dropped_q <= note_dropped_d;
            sample_q       <= sample_d;
            rank_q         <= rank_d;
        end
    end

    // A strobe already in flight is suppressed as soon as reset goes low.
    assign load             = load_q & {NUM_VOICES{reset}};
    assign load_note        = load_note_q & {NOTE_WIDTH{reset}};
    assign voice_busy       = busy_q;
    assign player_available = ~&busy_q;
    assign note_dropped     = note_dropped_q;
    assign sample_out       = sample_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, reset sequences, random vs. model.
`timescale 1ns/1ps
module tb_voice_allocator;
    localparam int NV = 3;
    localparam int SW = 16;
    localparam int NW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_note;
    logic [NW-1:0] note_in;
    logic [NV-1:0] voice_done;
    logic [NV*SW-1:0] voice_sample;
    logic [NV-1:0] load;
    logic [NW-1:0] load_note;
    logic [NV-1:0] voice_busy;
    logic          player_available;
    logic          note_dropped;
    logic [SW-1:0] sample_out;

    int errors = 0;
    int checks = 0;

    voice_allocator #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .NOTE_WIDTH(NW)) dut (
        .clk(clk), .reset(reset), .new_note(new_note), .note_in(note_in),
        .voice_done(voice_done), .voice_sample(voice_sample), .load(load),
        .load_note(load_note), .voice_busy(voice_busy), .player_available(player_available),
        .note_dropped(note_dropped), .sample_out(sample_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          nn;
        logic [NW-1:0] note;
        logic [NV-1:0] done;
        int            s0, s1, s2;
        logic [NV-1:0] e_load;
        logic [NW-1:0] e_note;
        logic [NV-1:0] e_busy;
        logic          e_drop;
        int            e_sample;
    } vec_t;
    vec_t vecs[13];

    // Reference model: occupancy flags plus a queue of busy voices, oldest first.
    bit            m_busy[NV];
    int            m_order[$];
    int            m_ptr;
    logic [NV-1:0] m_load;
    logic [NW-1:0] m_note;
    logic          m_drop;
    int            m_sample;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NV*SW-1:0] pack3(input int a, input int b, input int c);
        return {SW'(c), SW'(b), SW'(a)};
    endfunction

    function automatic int sat_mix(input logic [NV*SW-1:0] v);
        int sum;
        int hi;
        int lo;
        sum = 0;
        hi  = (1 << (SW - 1)) - 1;
        lo  = -(1 << (SW - 1));
        for (int i = 0; i < NV; i++) sum += int'($signed(v[i*SW +: SW]));
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) m_busy[i] = 1'b0;
        m_order.delete();
        m_ptr    = 0;
        m_load   = '0;
        m_note   = '0;
        m_drop   = 1'b0;
        m_sample = 0;
    endtask

    task automatic model_step(input logic nn, input logic [NW-1:0] nt, input logic [NV-1:0] dn,
                              input logic [NV*SW-1:0] smp);
        int k;
        m_load = '0;
        m_note = '0;
        m_drop = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (dn[i] && m_busy[i]) begin
                m_busy[i] = 1'b0;
                for (int j = 0; j < m_order.size(); j++) begin
                    if (m_order[j] == i) begin
                        m_order.delete(j);
                        break;
                    end
                end
            end
        end
        if (nn) begin
            k = -1;
            for (int off = 0; off < NV; off++)
                if (k < 0 && !m_busy[(m_ptr + off) % NV]) k = (m_ptr + off) % NV;
`ifdef VOICE_ALLOC_STEAL_EN
            if (k < 0) begin
                k = m_order[0];
                m_order.delete(0);
            end
`endif
            if (k >= 0) begin
                m_busy[k] = 1'b1;
                m_order.push_back(k);
                m_load[k] = 1'b1;
                m_note    = nt;
                m_ptr     = (k + 1) % NV;
            end else begin
                m_drop = 1'b1;
            end
        end
        m_sample = sat_mix(smp);
    endtask

    task automatic compare_all(input string tag);
        logic [NV-1:0] eb;
        for (int i = 0; i < NV; i++) eb[i] = m_busy[i];
        check({tag, "_load"},  32'(load),             32'(m_load));
        check({tag, "_note"},  32'(load_note),        32'(m_note));
        check({tag, "_busy"},  32'(voice_busy),       32'(eb));
        check({tag, "_avail"}, 32'(player_available), 32'(~&eb));
        check({tag, "_drop"},  32'(note_dropped),     32'(m_drop));
        check({tag, "_mix"},   32'(signed'(sample_out)), 32'(m_sample));
    endtask

    initial begin
        logic          r_nn;
        logic [NW-1:0] r_nt;
        logic [NV-1:0] r_dn;
        logic [NV*SW-1:0] r_smp;
        logic          r_rst;

        vecs[0]  = '{1'b1, 6'd5,  3'b000, 0, 0, 0, 3'b001, 6'd5,  3'b001, 1'b0, 0};
        vecs[1]  = '{1'b1, 6'd7,  3'b000, 0, 0, 0, 3'b010, 6'd7,  3'b011, 1'b0, 0};
        vecs[2]  = '{1'b1, 6'd9,  3'b000, 0, 0, 0, 3'b100, 6'd9,  3'b111, 1'b0, 0};
`ifdef VOICE_ALLOC_STEAL_EN
        vecs[3]  = '{1'b1, 6'd11, 3'b000, 0, 0, 0, 3'b001, 6'd11, 3'b111, 1'b0, 0};
`else
        vecs[3]  = '{1'b1, 6'd11, 3'b000, 0, 0, 0, 3'b000, 6'd0,  3'b111, 1'b1, 0};
`endif
        vecs[4]  = '{1'b1, 6'd13, 3'b010, 0, 0, 0, 3'b010, 6'd13, 3'b111, 1'b0, 0};
        vecs[5]  = '{1'b0, 6'd0,  3'b000, 30000, 30000, 10000, 3'b000, 6'd0, 3'b111, 1'b0, 32767};
        vecs[6]  = '{1'b0, 6'd0,  3'b000, -30000, -30000, -30000, 3'b000, 6'd0, 3'b111, 1'b0, -32768};
        vecs[7]  = '{1'b0, 6'd0,  3'b100, 0, 0, 0, 3'b000, 6'd0,  3'b011, 1'b0, 0};
        vecs[8]  = '{1'b1, 6'd20, 3'b000, 0, 0, 0, 3'b100, 6'd20, 3'b111, 1'b0, 0};
        vecs[9]  = '{1'b0, 6'd0,  3'b001, 0, 0, 0, 3'b000, 6'd0,  3'b110, 1'b0, 0};
        vecs[10] = '{1'b1, 6'd21, 3'b000, 0, 0, 0, 3'b001, 6'd21, 3'b111, 1'b0, 0};
        vecs[11] = '{1'b0, 6'd0,  3'b111, 0, 0, 0, 3'b000, 6'd0,  3'b000, 1'b0, 0};
        vecs[12] = '{1'b0, 6'd0,  3'b010, 100, -50, 7, 3'b000, 6'd0, 3'b000, 1'b0, 57};

        reset        = 1'b0;
        new_note     = 1'b0;
        note_in      = '0;
        voice_done   = '0;
        voice_sample = pack3(1000, -2000, 3000);
        tick();
        tick();
        check("rst_load",  32'(load),             32'd0);
        check("rst_note",  32'(load_note),        32'd0);
        check("rst_busy",  32'(voice_busy),       32'd0);
        check("rst_avail", 32'(player_available), 32'd1);
        check("rst_drop",  32'(note_dropped),     32'd0);
        check("rst_mix",   32'(sample_out),       32'd0);

        reset = 1'b1;
        for (int i = 0; i < 13; i++) begin
            new_note     = vecs[i].nn;
            note_in      = vecs[i].note;
            voice_done   = vecs[i].done;
            voice_sample = pack3(vecs[i].s0, vecs[i].s1, vecs[i].s2);
            tick();
            check($sformatf("v%0d_load", i),  32'(load),             32'(vecs[i].e_load));
            check($sformatf("v%0d_note", i),  32'(load_note),        32'(vecs[i].e_note));
            check($sformatf("v%0d_busy", i),  32'(voice_busy),       32'(vecs[i].e_busy));
            check($sformatf("v%0d_avail", i), 32'(player_available), 32'(~&vecs[i].e_busy));
            check($sformatf("v%0d_drop", i),  32'(note_dropped),     32'(vecs[i].e_drop));
            check($sformatf("v%0d_mix", i),   32'(signed'(sample_out)), 32'(vecs[i].e_sample));
        end

        // Reset arriving right after a request: the strobe must vanish and everything clears.
        new_note     = 1'b1;
        note_in      = 6'd33;
        voice_done   = '0;
        voice_sample = pack3(500, 500, 500);
        tick();
        check("pre_rst_load", 32'(load), 32'b010);
        new_note = 1'b0;
        reset    = 1'b0;
        #1;
        check("rst_gate_load", 32'(load),      32'd0);
        check("rst_gate_note", 32'(load_note), 32'd0);
        tick();
        check("rst2_load", 32'(load),         32'd0);
        check("rst2_busy", 32'(voice_busy),   32'd0);
        check("rst2_drop", 32'(note_dropped), 32'd0);
        check("rst2_mix",  32'(sample_out),   32'd0);

        // A request sampled under reset is discarded.
        new_note = 1'b1;
        note_in  = 6'd40;
        tick();
        reset    = 1'b1;
        new_note = 1'b0;
        tick();
        check("rst_req_load", 32'(load),       32'd0);
        check("rst_req_busy", 32'(voice_busy), 32'd0);

        // After reset the pointer is back at voice 0.
        new_note     = 1'b1;
        note_in      = 6'd5;
        voice_sample = '0;
        tick();
        check("post_rst_load", 32'(load),       32'b001);
        check("post_rst_note", 32'(load_note),  32'd5);
        check("post_rst_busy", 32'(voice_busy), 32'b001);

        // Random traffic against the reference model, with occasional resets.
        new_note = 1'b0;
        reset    = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            r_nn  = ($urandom_range(0, 99) < 55);
            r_nt  = NW'($urandom_range(0, (1 << NW) - 1));
            for (int i = 0; i < NV; i++) r_dn[i] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NV; i++) r_smp[i*SW +: SW] = SW'($urandom());
            r_rst = ($urandom_range(0, 99) < 3);
            new_note     = r_nn;
            note_in      = r_nt;
            voice_done   = r_dn;
            voice_sample = r_smp;
            reset        = ~r_rst;
            tick();
            if (r_rst) model_reset();
            else model_step(r_nn, r_nt, r_dn, r_smp);
            compare_all($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
